// File: rtl/tx_msg_seq_if.sv
// Host-side signal bundle for the 1553 transmit message sequencer.
interface tx_msg_seq_if;
  logic        st;
  logic [15:0] cw;
  logic [4:0]  dw_num;
  logic [15:0] dw_in;
  logic        dw_wr;
  logic        txen;
  logic [15:0] DAT;
  logic        word_strb;
  logic        is_cw;
  logic        busy;
  logic        done;
  logic        err;
  logic        ovf;
  logic [5:0]  fill;

  modport master (
    output st, cw, dw_num, dw_in, dw_wr,
    input  txen, DAT, word_strb, is_cw, busy, done, err, ovf, fill
  );

  modport slave (
    input  st, cw, dw_num, dw_in, dw_wr,
    output txen, DAT, word_strb, is_cw, busy, done, err, ovf, fill
  );
endinterface

// File: rtl/tx_msg_seq.sv
// 1553 transmit message sequencer: one command word slot followed by
// dw_num data word slots fed from a circular data-word FIFO.
module tx_msg_seq #(
  parameter int unsigned CLK_PER_WORD = 1000,
  parameter int unsigned MAX_DW       = 32
) (
  input  logic        clk,
  input  logic        rst,
  tx_msg_seq_if.slave bus
);

  localparam int unsigned CNT_W     = (CLK_PER_WORD > 1) ? $clog2(CLK_PER_WORD) : 1;
  localparam int unsigned PTR_W     = $clog2(MAX_DW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_WORD - 1);
  localparam logic [5:0]  FILL_FULL = 6'(MAX_DW);

  typedef enum logic [1:0] {S_IDLE, S_CW, S_DW} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:0]        r_rem;
  logic [4:0]        r_dwn;
  logic [15:0]       r_dat;
  logic              r_strb;
  logic              r_is_cw;
  logic              r_txen;
  logic              r_done;
  logic              r_err;
  logic              r_ovf;
  logic [5:0]        r_fill;
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [15:0]       r_mem [MAX_DW];

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [5:0]        w_rem_nxt;
  logic              w_slot_end;
  logic              w_dw_slot;
  logic              w_start;
  logic              w_pop;
  logic              w_flush;
  logic              w_strb_nxt;
  logic              w_is_cw_nxt;
  logic              w_txen_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_full;
  logic              w_wr_ok;
  logic              w_wr_drop;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_full     = (r_fill == FILL_FULL);

  // A pop frees a slot in the same cycle, so a write to a full buffer is
  // accepted when it coincides with a pop; a flush discards the write.
  assign w_wr_ok    = bus.dw_wr && !w_flush && (!w_full || w_pop);
  assign w_wr_drop  = bus.dw_wr && !w_flush && w_full && !w_pop;

  // Next-state, slot timing and next output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_dw_slot   = 1'b0;
    w_start     = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_strb_nxt  = 1'b0;
    w_is_cw_nxt = r_is_cw;
    w_txen_nxt  = r_txen;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_is_cw_nxt = 1'b0;
        w_txen_nxt  = 1'b0;
        if (bus.st) begin
          w_start     = 1'b1;
          w_state_nxt = S_CW;
          w_cnt_nxt   = '0;
          w_txen_nxt  = 1'b1;
          w_strb_nxt  = 1'b1;
          w_is_cw_nxt = 1'b1;
        end
      end
      S_CW: begin
        if (w_slot_end) begin
          w_cnt_nxt = '0;
          w_rem_nxt = (r_dwn == 5'd0) ? 6'd32 : {1'b0, r_dwn};
          w_dw_slot = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DW: begin
        if (w_slot_end) begin
          w_cnt_nxt = '0;
          if (r_rem == 6'd1) begin
            w_state_nxt = S_IDLE;
            w_txen_nxt  = 1'b0;
            w_is_cw_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_rem_nxt = r_rem - 6'd1;
            w_dw_slot = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Every data slot starts here: pop a word, or abort on an empty buffer.
    if (w_dw_slot) begin
      w_is_cw_nxt = 1'b0;
      if (r_fill == 6'd0) begin
        w_state_nxt = S_IDLE;
        w_txen_nxt  = 1'b0;
        w_err_nxt   = 1'b1;
        w_flush     = 1'b1;
      end else begin
        w_state_nxt = S_DW;
        w_pop       = 1'b1;
        w_strb_nxt  = 1'b1;
      end
    end
  end

  // FSM state, slot counter and remaining-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Registered outputs and the latched word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwn   <= '0;
      r_dat   <= '0;
      r_strb  <= 1'b0;
      r_is_cw <= 1'b0;
      r_txen  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_strb  <= w_strb_nxt;
      r_is_cw <= w_is_cw_nxt;
      r_txen  <= w_txen_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_start) begin
        r_dwn <= bus.dw_num;
        r_dat <= bus.cw;
      end else if (w_pop) begin
        r_dat <= r_mem[r_rd];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)   r_rd <= r_rd + PTR_W'(1);
      if (w_wr_ok && !w_pop)      r_fill <= r_fill + 6'd1;
      else if (w_pop && !w_wr_ok) r_fill <= r_fill - 6'd1;
      if (w_wr_drop) r_ovf <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) r_mem[r_wr] <= bus.dw_in;
  end

  assign bus.txen      = r_txen;
  assign bus.DAT       = r_dat;
  assign bus.word_strb = r_strb;
  assign bus.is_cw     = r_is_cw;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.ovf       = r_ovf;
  assign bus.fill      = r_fill;

endmodule
